// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Multi-cycle sequencer that owns the strobe pins of the 8-bit ALU. A requester
// hands over one operation (ADD, SUB, SHL, RDA) and its operands through a
// valid/ready handshake. The sequencer then walks the ALU through load-A,
// load-B, execute and read-back cycles. The 8-bit result and carry are
// returned through a second valid/ready handshake.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   req_valid/ready     request handshake
//   req_op              00 ADD, 01 SUB, 10 SHL, 11 RDA (read back A)
//   req_a, req_b        operands (req_b unused for SHL/RDA)
//   req_shift           shift amount for SHL
//   rsp_valid/ready     response handshake
//   rsp_data, rsp_carry result and carry/no-borrow/shift-out bit
//   alu_bus_out         data towards ALU bus_in (all-ones when nothing is written)
//   alu_bus_in          ALU bus_out
//   alu_carry_in        ALU carry_out
//   alu_enable, rega_enable, regb_enable,
//   rega_write_enable, regb_write_enable,
//   sub_enable, shift_enable, shift_pos   ALU strobes
//
// Every output is a flop. The ALU pins therefore never see a combinational
// path from req_* or rsp_ready.
// -----------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [2:0]       req_shift,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_carry,
   output logic [WIDTH-1:0] alu_bus_out,
   input  logic [WIDTH-1:0] alu_bus_in,
   input  logic             alu_carry_in,
   output logic             alu_enable,
   output logic             rega_enable,
   output logic             regb_enable,
   output logic             rega_write_enable,
   output logic             regb_write_enable,
   output logic             sub_enable,
   output logic             shift_enable,
   output logic [2:0]       shift_pos
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_SHL = 2'b10;
   localparam logic [1:0] OP_RDA = 2'b11;

   localparam logic [WIDTH-1:0] BUS_IDLE = {WIDTH{1'b1}};

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      EXEC   = 3'd3,
      READ   = 3'd4,
      RESP   = 3'd5
   } state_t;

   state_t           state_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] b_q;
   logic [2:0]       shift_q;
   logic             req_ready_q;
   logic             rsp_valid_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic             rsp_carry_q;
   logic [WIDTH-1:0] bus_q;
   logic             alu_en_q;
   logic             rega_en_q;
   logic             regb_en_q;
   logic             rega_we_q;
   logic             regb_we_q;
   logic             sub_en_q;
   logic             shift_en_q;
   logic [2:0]       shift_pos_q;

   // Sequencer FSM. Strobes are written together with the state, so they line
   // up with the state that is being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= OP_ADD;
         b_q         <= {WIDTH{1'b0}};
         shift_q     <= 3'd0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= {WIDTH{1'b0}};
         rsp_carry_q <= 1'b0;
         bus_q       <= BUS_IDLE;
         alu_en_q    <= 1'b0;
         rega_en_q   <= 1'b0;
         regb_en_q   <= 1'b0;
         rega_we_q   <= 1'b0;
         regb_we_q   <= 1'b0;
         sub_en_q    <= 1'b0;
         shift_en_q  <= 1'b0;
         shift_pos_q <= 3'd0;
      end else begin
         // Strobes drop every cycle unless the state being entered re-asserts them.
         bus_q       <= BUS_IDLE;
         alu_en_q    <= 1'b0;
         rega_en_q   <= 1'b0;
         regb_en_q   <= 1'b0;
         rega_we_q   <= 1'b0;
         regb_we_q   <= 1'b0;
         sub_en_q    <= 1'b0;
         shift_en_q  <= 1'b0;
         shift_pos_q <= 3'd0;
         case (state_q)
            IDLE: begin
               if (req_valid && req_ready_q) begin
                  op_q        <= req_op;
                  b_q         <= req_b;
                  shift_q     <= req_shift;
                  req_ready_q <= 1'b0;
                  // Operand A goes straight onto the bus for the LOAD_A cycle.
                  bus_q       <= req_a;
                  rega_we_q   <= 1'b1;
                  state_q     <= LOAD_A;
               end else begin
                  // Ready rises one cycle after reset release or after a handshake.
                  req_ready_q <= 1'b1;
               end
            end
            LOAD_A: begin
               case (op_q)
                  OP_RDA: begin
                     rega_en_q <= 1'b1;
                     state_q   <= READ;
                  end
                  OP_SHL: begin
                     shift_en_q  <= 1'b1;
                     shift_pos_q <= shift_q;
                     state_q     <= EXEC;
                  end
                  default: begin
                     bus_q     <= b_q;
                     regb_we_q <= 1'b1;
                     state_q   <= LOAD_B;
                  end
               endcase
            end
            LOAD_B: begin
               sub_en_q <= (op_q == OP_SUB);
               state_q  <= EXEC;
            end
            EXEC: begin
               // Op strobes are held through READ so the ALU output stays valid.
               sub_en_q    <= sub_en_q;
               shift_en_q  <= shift_en_q;
               shift_pos_q <= shift_pos_q;
               alu_en_q    <= 1'b1;
               state_q     <= READ;
            end
            READ: begin
               rsp_data_q  <= alu_bus_in;
               // The register read-back has no meaningful carry.
               rsp_carry_q <= (op_q == OP_RDA) ? 1'b0 : alu_carry_in;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  rsp_valid_q <= 1'b1;
                  req_ready_q <= 1'b0;
               end
            end
            default: begin
               req_ready_q <= 1'b0;
               rsp_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign req_ready         = req_ready_q;
   assign rsp_valid         = rsp_valid_q;
   assign rsp_data          = rsp_data_q;
   assign rsp_carry         = rsp_carry_q;
   assign alu_bus_out       = bus_q;
   assign alu_enable        = alu_en_q;
   assign rega_enable       = rega_en_q;
   assign regb_enable       = regb_en_q;
   assign rega_write_enable = rega_we_q;
   assign regb_write_enable = regb_we_q;
   assign sub_enable        = sub_en_q;
   assign shift_enable      = shift_en_q;
   assign shift_pos         = shift_pos_q;

endmodule
